// File: rtl/jk_updown_counter_pkg.sv
// jk_updown_counter_pkg: JK mode encoding and default counter width
package jk_updown_counter_pkg;
    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] CLR  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TOG  = 2'b11;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/jk_updown_counter_jk_ff.sv
// jk_ff: JK flip-flop with asynchronous active-high reset to 0
module jk_ff
    import jk_updown_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);
    logic [1:0] mode;
    assign mode = {j, k};
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= 1'b0;
        else q <= (mode == HOLD) ? q : (mode == SET) ? 1'b1 : (mode == CLR) ? 1'b0 : ~q;
endmodule

// File: rtl/jk_updown_counter.sv
// jk_updown_counter: up/down counter built from JK flip-flops with wrap or saturate limits
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);
    logic [WIDTH-1:0] up_chain, dn_chain, tog, j, k;
    logic step;
    assign tc = up ? &count : ~|count;
    // a bit toggles when every lower bit is 1 (counting up) or 0 (counting down)
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign up_chain[i] = 1'b1;
            assign dn_chain[i] = 1'b1;
        end else begin : g_chain
            assign up_chain[i] = up_chain[i-1] & count[i-1];
            assign dn_chain[i] = dn_chain[i-1] & ~count[i-1];
        end
        jk_ff u_ff (.clk(clk), .reset(reset), .j(j[i]), .k(k[i]), .q(count[i]));
    end
    always_comb begin
        step = en && !(SATURATE && tc);
        tog  = step ? (up ? up_chain : dn_chain) : '0;
        j    = load ? load_val : tog;
        k    = load ? ~load_val : tog;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) wrap <= 1'b0;
        else wrap <= !load && en && tc && !SATURATE;
endmodule

// File: tb/tb_jk_updown_counter.sv
// tb_jk_updown_counter: checks wrap and saturate counters and the jk_ff cell against a reference model
module tb_jk_updown_counter;
    logic clk = 1'b0;
    logic reset, en, up, load;
    logic [3:0] load_val;
    logic [3:0] count0, count1;
    logic tc0, tc1, wrap0, wrap1;
    logic ff_reset, fj, fk, fq;
    logic [3:0] mc0, mc1;
    logic mw0, mw1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jk_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count0), .tc(tc0), .wrap(wrap0));
    jk_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count1), .tc(tc1), .wrap(wrap1));
    jk_ff u_ff (.clk(clk), .reset(ff_reset), .j(fj), .k(fk), .q(fq));

    // returns {wrap, count} after one edge, from the arithmetic rules
    function automatic logic [4:0] nxt(input logic [3:0] c, input bit sat, input bit l,
                                       input bit e, input bit u, input logic [3:0] lv);
        if (l) return {1'b0, lv};
        if (!e) return {1'b0, c};
        if (u && c == 4'd15) return sat ? {1'b0, c} : {1'b1, 4'd0};
        if (!u && c == 4'd0) return sat ? {1'b0, c} : {1'b1, 4'd15};
        return {1'b0, u ? c + 4'd1 : c - 4'd1};
    endfunction

    task automatic tick();
        if (reset) begin
            mc0 = 0; mc1 = 0; mw0 = 0; mw1 = 0;
        end else begin
            {mw0, mc0} = nxt(mc0, 1'b0, load, en, up, load_val);
            {mw1, mc1} = nxt(mc1, 1'b1, load, en, up, load_val);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1; en = 0; up = 0; load = 0; load_val = 0;
        mc0 = 0; mc1 = 0; mw0 = 0; mw1 = 0;
        #3;
        checks++;
        if (count0 !== 4'd0 || wrap0 !== 1'b0 || count1 !== 4'd0 || wrap1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state count0=%0d wrap0=%0b count1=%0d wrap1=%0b required 0/0/0/0", count0, wrap0, count1, wrap1);
        end
        checks++;
        if (tc0 !== 1'b1) begin failures++; $display("FAIL reset_tc_down got %0b required 1", tc0); end
        up = 1; #1;
        checks++;
        if (tc0 !== 1'b0) begin failures++; $display("FAIL reset_tc_up got %0b required 0", tc0); end
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic test_count_up();
        int wraps = 0;
        en = 1; up = 1; load = 0;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (tc0 !== (mc0 == 4'd15)) begin failures++; $display("FAIL up_tc step %0d got %0b required %0b", i, tc0, mc0 == 4'd15); end
            tick();
            wraps += wrap0;
            checks++;
            if (count0 !== 4'((i + 1) % 16) || wrap0 !== mw0) begin
                failures++;
                $display("FAIL up_count step %0d count=%0d wrap=%0b required %0d/%0b", i, count0, wrap0, (i + 1) % 16, mw0);
            end
        end
        checks++;
        if (wraps != 1) begin failures++; $display("FAIL up_wrap_pulses got %0d required 1", wraps); end
    endtask

    task automatic test_load_down();
        int wraps = 0;
        load = 1; load_val = 4'h3; en = 0;
        tick();
        checks++;
        if (count0 !== 4'd3) begin failures++; $display("FAIL load3 got %0d required 3", count0); end
        load = 0; en = 1; up = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            wraps += wrap0;
            checks++;
            if (count0 !== mc0 || wrap0 !== mw0) begin
                failures++;
                $display("FAIL down_count step %0d count=%0d wrap=%0b required %0d/%0b", i, count0, wrap0, mc0, mw0);
            end
        end
        checks++;
        if (count0 !== 4'd14 || wraps != 1) begin failures++; $display("FAIL down_end count=%0d wraps=%0d required 14/1", count0, wraps); end
    endtask

    task automatic test_saturate();
        load = 1; load_val = 4'hE; en = 0;
        tick();
        load = 0; en = 1; up = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count1 !== 4'd15 || wrap1 !== 1'b0 || count0 !== mc0 || wrap0 !== mw0) begin
                failures++;
                $display("FAIL sat_up step %0d count1=%0d wrap1=%0b count0=%0d wrap0=%0b required 15/0/%0d/%0b", i, count1, wrap1, count0, wrap0, mc0, mw0);
            end
        end
        up = 0;
        tick();
        checks++;
        if (count1 !== 4'd14 || wrap1 !== 1'b0) begin failures++; $display("FAIL sat_down got %0d/%0b required 14/0", count1, wrap1); end
    endtask

    task automatic test_load_priority();
        load = 1; load_val = 4'h5; en = 0;
        tick();
        en = 1; up = 1; load_val = 4'h9;
        tick();
        checks++;
        if (count0 !== 4'd9 || wrap0 !== 1'b0) begin failures++; $display("FAIL load_wins got %0d/%0b required 9/0", count0, wrap0); end
        load_val = 4'hF; en = 0;
        tick();
        en = 1; load_val = 4'h2;
        tick();
        checks++;
        if (count0 !== 4'd2 || wrap0 !== 1'b0) begin failures++; $display("FAIL load_at_limit got %0d/%0b required 2/0", count0, wrap0); end
        load = 0;
    endtask

    task automatic test_async_reset();
        load = 1; load_val = 4'h7; en = 0;
        tick();
        load = 0; en = 1; up = 1;
        #2 reset = 1; #1;
        checks++;
        if (count0 !== 4'd0 || count1 !== 4'd0) begin failures++; $display("FAIL async_reset got %0d/%0d required 0/0", count0, count1); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count0 !== 4'd0 || wrap0 !== 1'b0) begin failures++; $display("FAIL held_reset got %0d/%0b required 0/0", count0, wrap0); end
        end
        reset = 0;
        tick();
        checks++;
        if (count0 !== 4'd1 || count1 !== 4'd1) begin failures++; $display("FAIL first_after_reset got %0d/%0d required 1/1", count0, count1); end
        load = 1; load_val = 4'hF;
        tick();
        load = 0;
        #2 reset = 1; #1;
        tick();
        checks++;
        if (count0 !== 4'd0 || wrap0 !== 1'b0) begin failures++; $display("FAIL reset_no_wrap got %0d/%0b required 0/0", count0, wrap0); end
        reset = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            load = ($urandom_range(7) == 0);
            en = ($urandom_range(3) != 0);
            up = $urandom_range(1);
            load_val = 4'($urandom);
            #1;
            checks++;
            if (tc0 !== (up ? mc0 == 4'd15 : mc0 == 4'd0)) begin failures++; $display("FAIL rand_tc iter %0d got %0b count=%0d up=%0b", i, tc0, mc0, up); end
            tick();
            checks++;
            if (count0 !== mc0 || wrap0 !== mw0 || count1 !== mc1 || wrap1 !== mw1) begin
                failures++;
                $display("FAIL rand_step iter %0d got %0d/%0b %0d/%0b required %0d/%0b %0d/%0b", i, count0, wrap0, count1, wrap1, mc0, mw0, mc1, mw1);
            end
        end
    endtask

    task automatic test_jk_ff();
        logic expq;
        ff_reset = 1; fj = 0; fk = 0; #1;
        checks++;
        if (fq !== 1'b0) begin failures++; $display("FAIL ff_reset got %0b required 0", fq); end
        ff_reset = 0;
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 4; m++) begin
                fj = s[0]; fk = !s[0];
                @(posedge clk); #1;
                {fj, fk} = 2'(m);
                expq = (m == 0) ? s[0] : (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : !s[0];
                @(posedge clk); #1;
                checks++;
                if (fq !== expq) begin failures++; $display("FAIL ff_jk q0=%0d jk=%0d got %0b required %0b", s, m, fq, expq); end
            end
        end
        fj = 1; fk = 0;
        @(posedge clk); #2;
        ff_reset = 1; #1;
        checks++;
        if (fq !== 1'b0) begin failures++; $display("FAIL ff_async_reset got %0b required 0", fq); end
        ff_reset = 0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_down();
        test_saturate();
        test_load_priority();
        test_async_reset();
        test_random();
        test_jk_ff();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
